data_mem: RTL and testbench



---
 rtl/mem_pkg.sv | 25 ++
 rtl/data_mem_if.sv | 24 ++
 rtl/load_ext.sv | 27 ++
 rtl/data_mem.sv | 59 +++++
 tb/tb_data_mem.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared constants for the data memory: funct3 access codes, default size, store lane decode.
// Pure declarations; no timing and no flow control.
package mem_pkg;

  localparam int ADDR_W_DEFAULT = 10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte-lane enables within the aligned word; unsupported store widths enable nothing.
  function automatic logic [3:0] store_lanes(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] lanes;
    case (f3)
      F3_B:    lanes = 4'b0001 << off;
      F3_H:    lanes = off[1] ? 4'b1100 : 4'b0011;
      F3_W:    lanes = 4'b1111;
      default: lanes = 4'b0000;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/data_mem_if.sv
// Load/store bus between the load/store unit (master) and data_mem (slave).
// Loads are combinational, stores commit on the clock edge; there is no handshake.
interface data_mem_if import mem_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEFAULT
);

  logic              MemRead;
  logic              MemWrite;
  logic [2:0]        F3;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data_in;
  logic [31:0]       data_out;

  modport master (
    output MemRead, MemWrite, F3, addr, data_in,
    input  data_out
  );

  modport slave (
    input  MemRead, MemWrite, F3, addr, data_in,
    output data_out
  );

endinterface

// File: rtl/load_ext.sv
// Selects the byte/halfword from an aligned word and sign- or zero-extends it by funct3.
// Purely combinational (0 cycles); no flow control.
module load_ext import mem_pkg::*; (
  input  logic [31:0] word,
  input  logic [1:0]  off,
  input  logic [2:0]  f3,
  output logic [31:0] dat
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{off, 3'b000} +: 8];
    half_sel = off[1] ? word[31:16] : word[15:0];
    dat      = '0;
    case (f3)
      F3_B:    dat = {{24{byte_sel[7]}}, byte_sel};
      F3_H:    dat = {{16{half_sel[15]}}, half_sel};
      F3_W:    dat = word;
      F3_BU:   dat = {24'b0, byte_sel};
      F3_HU:   dat = {16'b0, half_sel};
      default: dat = '0;
    endcase
  end

endmodule

// File: rtl/data_mem.sv
// Byte-addressable RV32I data memory: little-endian byte-lane stores, extended loads.
// Loads 0-cycle combinational, stores commit on rising clk; accepts an access every cycle.
module data_mem import mem_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input logic        clk,
  input logic        rst,
  data_mem_if.slave  bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-3:0] word_idx;
  logic [3:0]        wr_lanes;
  logic [31:0]       wr_lane_dat;
  logic [31:0]       rd_word;
  logic [31:0]       ext_dat;

  assign word_idx = bus.addr[ADDR_W-1:2];
  assign wr_lanes = bus.MemWrite ? store_lanes(bus.F3, bus.addr[1:0]) : 4'b0000;

  // Replicate narrow store data across lanes so each lane just picks its own byte.
  always_comb begin
    wr_lane_dat = bus.data_in;
    case (bus.F3)
      F3_B:    wr_lane_dat = {4{bus.data_in[7:0]}};
      F3_H:    wr_lane_dat = {2{bus.data_in[15:0]}};
      default: wr_lane_dat = bus.data_in;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int l = 0; l < 4; l++) begin
        if (wr_lanes[l]) begin
          mem[{word_idx, 2'(l)}] <= wr_lane_dat[8*l +: 8];
        end
      end
    end
  end

  assign rd_word = {mem[{word_idx, 2'd3}], mem[{word_idx, 2'd2}],
                    mem[{word_idx, 2'd1}], mem[{word_idx, 2'd0}]};

  load_ext u_load_ext (
    .word (rd_word),
    .off  (bus.addr[1:0]),
    .f3   (bus.F3),
    .dat  (ext_dat)
  );

  assign bus.data_out = (bus.MemRead && !rst) ? ext_dat : 32'h0;

endmodule

// File: tb/tb_data_mem.sv
// Self-checking bench for data_mem: directed load/store cases plus a random sweep
// against a byte-array reference; expected values go through a scoreboard queue.
module tb_data_mem;
  import mem_pkg::*;

  localparam int AW = 10;

  logic clk;
  logic rst;

  data_mem_if #(.ADDR_W(AW)) bus ();

  data_mem #(.ADDR_W(AW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          n_chk;
  int          n_err;
  logic [31:0] sb_q [$];
  logic [7:0]  ref_mem [1024];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Pop the oldest expectation and compare it against the current output.
  task automatic sb_check(input string tag);
    logic [31:0] exp;
    if (sb_q.size() == 0) begin
      n_chk++;
      n_err++;
      $display("FAIL %s got=empty_queue exp=entry", tag);
    end else begin
      exp = sb_q.pop_front();
      chk(tag, bus.data_out, exp);
    end
  endtask

  task automatic model_write(input logic [2:0] f3, input int a, input logic [31:0] d);
    int base;
    case (f3)
      3'b000: ref_mem[a] = d[7:0];
      3'b001: begin
        base = a - (a % 2);
        ref_mem[base]     = d[7:0];
        ref_mem[base + 1] = d[15:8];
      end
      3'b010: begin
        base = a - (a % 4);
        for (int k = 0; k < 4; k++) ref_mem[base + k] = d[8*k +: 8];
      end
      default: ;
    endcase
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input int a);
    int          hb;
    int          wb;
    logic [7:0]  b;
    logic [15:0] h;
    hb = a - (a % 2);
    wb = a - (a % 4);
    b  = ref_mem[a];
    h  = {ref_mem[hb + 1], ref_mem[hb]};
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b010:  return {ref_mem[wb + 3], ref_mem[wb + 2], ref_mem[wb + 1], ref_mem[wb]};
      3'b100:  return {24'b0, b};
      3'b101:  return {16'b0, h};
      default: return 32'h0;
    endcase
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic st(input logic [2:0] f3, input int a, input logic [31:0] d);
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b1;
    bus.F3       = f3;
    bus.addr     = 10'(a);
    bus.data_in  = d;
    @(posedge clk);
    #1;
    bus.MemWrite = 1'b0;
    if (!rst) model_write(f3, a, d);
    @(negedge clk);
  endtask

  task automatic ld(input string tag, input logic [2:0] f3, input int a, input logic [31:0] exp);
    bus.MemRead  = 1'b1;
    bus.MemWrite = 1'b0;
    bus.F3       = f3;
    bus.addr     = 10'(a);
    sb_q.push_back(exp);
    #1;
    sb_check(tag);
    @(negedge clk);
  endtask

  initial begin
    logic [2:0]  rf3;
    logic [31:0] rd;
    int          ra;
    n_chk        = 0;
    n_err        = 0;
    rst          = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.F3       = F3_W;
    bus.addr     = '0;
    bus.data_in  = '0;
    @(negedge clk);

    // Put something nonzero in memory, then reset asynchronously mid-cycle.
    st(F3_W, 4, 32'h12345678);
    bus.MemRead = 1'b1;
    bus.F3      = F3_W;
    bus.addr    = 10'd4;
    #3;
    rst = 1'b1;
    #1;
    sb_q.push_back(32'h0);
    sb_check("rst_hold_lw4");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    ld("rst_lw0", F3_W, 0, 32'h0);
    ld("rst_lw4", F3_W, 4, 32'h0);
    ld("rst_lw1020", F3_W, 1020, 32'h0);

    // A store during reset must be dropped.
    rst = 1'b1;
    st(F3_W, 0, 32'hDEADBEEF);
    rst = 1'b0;
    ld("rst_blocks_wr", F3_W, 0, 32'h0);

    st(F3_W, 0, 32'h88888888);
    ld("lw0", F3_W, 0, 32'h88888888);
    ld("lb0", F3_B, 0, 32'hFFFFFF88);
    ld("lbu3", F3_BU, 3, 32'h00000088);
    ld("lh2", F3_H, 2, 32'hFFFF8888);
    ld("lhu0", F3_HU, 0, 32'h00008888);

    st(F3_H, 4, 32'h88888888);
    st(F3_H, 6, 32'h12345678);
    ld("sh_lw4", F3_W, 4, 32'h56788888);
    st(F3_H, 5, 32'h0000AAAA);
    ld("sh_misalign", F3_W, 4, 32'h5678AAAA);

    st(F3_B, 8, 32'h00000088);
    st(F3_B, 9, 32'h00000001);
    st(F3_B, 10, 32'h0000007F);
    st(F3_B, 11, 32'h000000FE);
    ld("sb_lw8", F3_W, 8, 32'hFE7F0188);
    ld("lb10", F3_B, 10, 32'h0000007F);
    ld("lb11", F3_B, 11, 32'hFFFFFFFE);
    ld("lhu10", F3_HU, 10, 32'h0000FE7F);
    ld("lhu11", F3_HU, 11, 32'h0000FE7F);
    ld("lh9", F3_H, 9, 32'h00000188);
    ld("lb8", F3_B, 8, 32'hFFFFFF88);
    ld("lw9_align", F3_W, 9, 32'hFE7F0188);

    // Write with MemRead low: output stays 0 and the store lands.
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b1;
    bus.F3       = F3_W;
    bus.addr     = 10'd12;
    bus.data_in  = 32'h33333333;
    #1;
    chk("rd0_pre", bus.data_out, 32'h0);
    @(posedge clk);
    #1;
    chk("rd0_post", bus.data_out, 32'h0);
    bus.MemWrite = 1'b0;
    model_write(F3_W, 12, 32'h33333333);
    @(negedge clk);
    ld("rd0_commit", F3_W, 12, 32'h33333333);

    st(3'b011, 12, 32'h44444444);
    st(3'b111, 12, 32'h55555555);
    ld("bad_st", F3_W, 12, 32'h33333333);
    ld("f3_110", 3'b110, 12, 32'h0);
    ld("f3_011", 3'b011, 12, 32'h0);
    ld("f3_111", 3'b111, 12, 32'h0);

    // Read-during-write: old data before the edge, new data after.
    st(F3_W, 0, 32'h11111111);
    bus.MemRead  = 1'b1;
    bus.MemWrite = 1'b1;
    bus.F3       = F3_W;
    bus.addr     = 10'd0;
    bus.data_in  = 32'h22222222;
    sb_q.push_back(32'h11111111);
    #1;
    sb_check("rdw_old");
    @(posedge clk);
    #1;
    sb_q.push_back(32'h22222222);
    sb_check("rdw_new");
    bus.MemWrite = 1'b0;
    model_write(F3_W, 0, 32'h22222222);
    @(negedge clk);

    st(F3_W, 1020, 32'hCAFEF00D);
    ld("lw1020", F3_W, 1020, 32'hCAFEF00D);
    ld("lw0_intact", F3_W, 0, 32'h22222222);
    ld("lbu1023", F3_BU, 1023, 32'h000000CA);

    // Random mix of stores and loads against the byte-array reference.
    for (int i = 0; i < 60; i++) begin
      rf3 = 3'($urandom_range(0, 3));
      ra  = $urandom_range(0, 63);
      rd  = $urandom;
      st(rf3, ra, rd);
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom_range(0, 63);
      ld("rand", rf3, ra, model_load(rf3, ra));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
